// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with enable, synchronous load, and wrap-or-saturate boundaries.
// Emits registered wrap/load_clip event pulses and a combinational terminal-count flag.
module updown_mod_counter #(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             sat,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             load_clip
);

    generate
        if (WIDTH < 1 || WIDTH > 16 || MODULUS < 2 || MODULUS > (1 << WIDTH) ||
            RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_params
            $fatal(1, "updown_mod_counter: illegal WIDTH/MODULUS/RESET_VAL combination");
        end
    endgenerate

    // Upper bound kept in WIDTH bits so MODULUS == 2**WIDTH never needs an extra bit.
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q   = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             clip_next;

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        clip_next = 1'b0;
        if (load) begin
            if (din > MAX_VAL) begin
                q_next    = MAX_VAL;
                clip_next = 1'b1;
            end else begin
                q_next = din;
            end
        end else if (en) begin
            if (up_dn) begin
                if (q != MAX_VAL) begin
                    q_next = q + WIDTH'(1);
                end else if (!sat) begin
                    q_next    = '0;
                    wrap_next = 1'b1;
                end
            end else begin
                if (q != '0) begin
                    q_next = q - WIDTH'(1);
                end else if (!sat) begin
                    q_next    = MAX_VAL;
                    wrap_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q         <= RST_Q;
            wrap      <= 1'b0;
            load_clip <= 1'b0;
        end else begin
            q         <= q_next;
            wrap      <= wrap_next;
            load_clip <= clip_next;
        end
    end

    // Terminal count tracks up_dn with no clock in between.
    assign tc = up_dn ? (q == MAX_VAL) : (q == '0);

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: a MODULUS=10 instance (reset value 3)
// and a full-range WIDTH=3/MODULUS=8 instance, checked with immediate assertions.
module tb_updown_mod_counter;

    logic       clk;
    int         n_checks;
    int         n_fail;

    // Instance A: WIDTH=4, MODULUS=10, RESET_VAL=3
    logic       rst_a, en_a, up_dn_a, load_a, sat_a;
    logic [3:0] din_a;
    logic [3:0] q_a;
    logic       tc_a, wrap_a, clip_a;

    // Instance B: WIDTH=3, MODULUS=8, RESET_VAL=0
    logic       rst_b, en_b, up_dn_b, load_b, sat_b;
    logic [2:0] din_b;
    logic [2:0] q_b;
    logic       tc_b, wrap_b, clip_b;

    updown_mod_counter #(.WIDTH(4), .MODULUS(10), .RESET_VAL(3)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .up_dn(up_dn_a), .load(load_a),
        .din(din_a), .sat(sat_a), .q(q_a), .tc(tc_a), .wrap(wrap_a), .load_clip(clip_a)
    );

    updown_mod_counter #(.WIDTH(3), .MODULUS(8), .RESET_VAL(0)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .up_dn(up_dn_b), .load(load_b),
        .din(din_b), .sat(sat_b), .q(q_b), .tc(tc_b), .wrap(wrap_b), .load_clip(clip_b)
    );

    // Clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_a(input string tag, input int eq, input int ewrap, input int eclip, input int etc);
        check({tag, ".q"},    32'(q_a),    32'(eq));
        check({tag, ".wrap"}, 32'(wrap_a), 32'(ewrap));
        check({tag, ".clip"}, 32'(clip_a), 32'(eclip));
        check({tag, ".tc"},   32'(tc_a),   32'(etc));
    endtask

    task automatic check_b(input string tag, input int eq, input int ewrap, input int etc);
        check({tag, ".q"},    32'(q_b),    32'(eq));
        check({tag, ".wrap"}, 32'(wrap_b), 32'(ewrap));
        check({tag, ".tc"},   32'(tc_b),   32'(etc));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_a = 1'b1; en_a = 1'b0; up_dn_a = 1'b1; load_a = 1'b0; sat_a = 1'b0; din_a = '0;
        rst_b = 1'b1; en_b = 1'b0; up_dn_b = 1'b1; load_b = 1'b0; sat_b = 1'b0; din_b = '0;

        // Asynchronous reset between edges
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        check_a("reset_async", 3, 0, 0, 0);
        check_b("b_reset", 0, 0, 0);
        en_a = 1'b1;
        step();
        check_a("reset_hold", 3, 0, 0, 0);
        #1;
        rst_a = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        step();
        check_a("reset_first_count", 4, 0, 0, 0);

        // Up wrap from 0 through 9 and back to 0
        load_a = 1'b1; din_a = 4'd0;
        step();
        check_a("load0", 0, 0, 0, 0);
        load_a = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            step();
            check_a("up_seq", i, 0, 0, (i == 9) ? 1 : 0);
        end
        step();
        check_a("up_wrap", 0, 1, 0, 0);
        step();
        check_a("up_after_wrap", 1, 0, 0, 0);

        // Down wrap from 1
        up_dn_a = 1'b0;
        #1;
        check("down_tc_q1", 32'(tc_a), 32'd0);
        step();
        check_a("down_to0", 0, 0, 0, 1);
        step();
        check_a("down_wrap", 9, 1, 0, 0);

        // Down saturate at 0
        load_a = 1'b1; din_a = 4'd0; sat_a = 1'b1;
        step();
        load_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_a("down_sat", 0, 0, 0, 1);
        end

        // Up saturate at 9
        up_dn_a = 1'b1;
        load_a = 1'b1; din_a = 4'd9;
        step();
        load_a = 1'b0;
        step();
        check_a("up_sat", 9, 0, 0, 1);
        sat_a = 1'b0;

        // Load priority over en, then clipped load
        en_a = 1'b1; load_a = 1'b1; din_a = 4'd7;
        step();
        check_a("load_prio", 7, 0, 0, 0);
        din_a = 4'd12;
        step();
        check_a("load_clip", 9, 0, 1, 1);
        load_a = 1'b0; en_a = 1'b0;
        step();
        check_a("hold_after_clip", 9, 0, 0, 1);
        step();
        check_a("hold_again", 9, 0, 0, 1);

        // Direction flip at the bound, no edge
        up_dn_a = 1'b0;
        #1;
        check("flip_tc", 32'(tc_a), 32'd0);
        en_a = 1'b1;
        step();
        check_a("flip_count", 8, 0, 0, 0);

        // Reset mid-count clears a pending wrap
        up_dn_a = 1'b1;
        load_a = 1'b1; din_a = 4'd9;
        step();
        load_a = 1'b0;
        step();
        check_a("pre_reset_wrap", 0, 1, 0, 0);
        #2;
        rst_a = 1'b0;
        #1;
        check_a("reset_midcount", 3, 0, 0, 0);
        #1;
        rst_a = 1'b1;
        step();
        check_a("post_reset_count", 4, 0, 0, 0);

        // Full-range modulus instance
        load_b = 1'b1; din_b = 3'd7;
        step();
        check_b("b_load7", 7, 0, 1);
        check("b_clip", 32'(clip_b), 32'd0);
        load_b = 1'b0; en_b = 1'b1;
        step();
        check_b("b_up_wrap", 0, 1, 0);
        up_dn_b = 1'b0;
        step();
        check_b("b_down_wrap", 7, 1, 0);
        step();
        check_b("b_down", 6, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
